// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data-SRAM responder: bus widths, default depth, wait-state limit.
package data_sram_resp_pkg;
  localparam int DSRAM_BUS_ADDR_W = 32;
  localparam int DSRAM_BUS_DATA_W = 32;
  localparam int DSRAM_BUS_WEN_W  = 4;
  localparam int DSRAM_ADDR_W     = 10;
  localparam int DSRAM_WAIT_MAX   = 15;
  localparam int DSRAM_CNT_W      = 4;
endpackage

// File: rtl/dsram_bank.sv
// Word-organised data store: byte-lane write port and registered read port, no reset.
module dsram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W = DSRAM_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rd_en_i,
  input  logic [DSRAM_BUS_WEN_W-1:0]  wen_i,
  input  logic [ADDR_W-1:0]           idx_i,
  input  logic [DSRAM_BUS_DATA_W-1:0] wdata_i,
  output logic [DSRAM_BUS_DATA_W-1:0] rdata_o
);
  logic [DSRAM_BUS_DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DSRAM_BUS_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DSRAM_BUS_WEN_W; i++)
      if (wen_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (rd_en_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: wait-state counter, stall request, and reset-clean read data around dsram_bank.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W      = DSRAM_ADDR_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_sram_en,
  input  logic [DSRAM_BUS_WEN_W-1:0]  data_sram_wen,
  input  logic [DSRAM_BUS_ADDR_W-1:0] data_sram_addr,
  input  logic [DSRAM_BUS_DATA_W-1:0] data_sram_wdata,
  output logic [DSRAM_BUS_DATA_W-1:0] data_sram_rdata,
  output logic                        stallreq
);
  localparam logic [DSRAM_CNT_W-1:0] WAIT_L = DSRAM_CNT_W'(WAIT_CYCLES);

  logic [DSRAM_CNT_W-1:0]      cnt_q, cnt_d;
  logic                        rvalid_q, rvalid_d;
  logic                        hit, fire, rd_fire;
  logic [DSRAM_BUS_WEN_W-1:0]  bank_wen;
  logic [DSRAM_BUS_DATA_W-1:0] bank_rdata;
  logic                        unused_addr;

  // Gating with rst keeps a held request from stalling or writing during reset.
  assign hit      = (cnt_q == WAIT_L);
  assign fire     = data_sram_en && hit && !rst;
  assign stallreq = data_sram_en && !hit && !rst;
  assign rd_fire  = fire && (data_sram_wen == '0);
  assign bank_wen = fire ? data_sram_wen : '0;

  always_comb begin
    cnt_d    = '0;
    rvalid_d = rvalid_q;
    if (fire)              cnt_d = '0;
    else if (data_sram_en) cnt_d = cnt_q + 1'b1;
    if (rd_fire)           rvalid_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  dsram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk     (clk),
    .rd_en_i (rd_fire),
    .wen_i   (bank_wen),
    .idx_i   (data_sram_addr[ADDR_W+1:2]),
    .wdata_i (data_sram_wdata),
    .rdata_o (bank_rdata)
  );

  // The bank register has no reset, so read data is masked until the first read after reset.
  assign data_sram_rdata = rvalid_q ? bank_rdata : '0;

  assign unused_addr = ^{data_sram_addr[DSRAM_BUS_ADDR_W-1:ADDR_W+2], data_sram_addr[1:0]};
endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench: three responders (wait 0, 2, 3) driven with directed accesses.
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en    [3];
  logic [3:0]  wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];

  typedef struct { int d; logic [31:0] data; } exp_t;
  exp_t        q[$];
  logic [31:0] last_rd [3];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_rdata(rdata[0]), .stallreq(stall[0]));
  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_rdata(rdata[1]), .stallreq(stall[1]));
  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
    .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]),
    .data_sram_rdata(rdata[2]), .stallreq(stall[2]));

  function automatic int wt(int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; pushes the expected rdata once the access fires.
  task automatic access(int d, logic [3:0] w, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] exp, string name);
    en[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    for (int k = 0; k <= wt(d); k++) begin
      #1;
      chk({name, " stallreq"}, 32'(stall[d]), 32'(k < wt(d)));
      if (k < wt(d)) chk({name, " rdata hold"}, rdata[d], last_rd[d]);
      @(posedge clk);
      if (k == wt(d)) begin
        #1;
        if (w == 4'h0) last_rd[d] = exp;
        q.push_back('{d, last_rd[d]});
      end
      @(negedge clk);
    end
    en[d] = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("rdata[%0d]", e.d), rdata[e.d], e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; wen[d] = '0; addr[d] = '0; wdata[d] = '0; last_rd[d] = '0;
    end
    en[2] = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset rdata[%0d]", d), rdata[d], 32'h0);
      chk($sformatf("reset stallreq[%0d]", d), 32'(stall[d]), 32'h0);
    end
    rst = 1'b0; en[2] = 1'b0;

    // Reset in the middle of a stalled write on the wait-3 port
    access(2, 4'hF, 32'h30, 32'hCAFEF00D, 32'h0, "w30");
    access(2, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D, "r30");
    en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h30; wdata[2] = 32'h0;
    repeat (2) begin
      #1 chk("midrst stallreq pre", 32'(stall[2]), 32'h1);
      @(posedge clk); @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst stallreq", 32'(stall[2]), 32'h0);
    chk("midrst rdata", rdata[2], 32'h0);
    for (int d = 0; d < 3; d++) last_rd[d] = '0;
    @(negedge clk);
    rst = 1'b0; en[2] = 1'b0;
    access(2, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D, "r30 after rst");

    // Full word write then read, no wait states
    access(0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, "w10");
    access(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, "r10");

    // Byte lanes
    access(0, 4'hF, 32'h20, 32'h11223344, 32'h0, "w20 pre");
    access(0, 4'b0100, 32'h20, 32'h00AA0000, 32'h0, "w20 lane2");
    access(0, 4'h0, 32'h20, 32'h0, 32'h11AA3344, "r20 a");
    access(0, 4'b0011, 32'h20, 32'h0000BBCC, 32'h0, "w20 lane10");
    access(0, 4'h0, 32'h20, 32'h0, 32'h11AABBCC, "r20 b");

    // Aliasing and ignored low address bits
    access(0, 4'hF, 32'h1004, 32'h00000055, 32'h0, "w1004");
    access(0, 4'h0, 32'h0004, 32'h0, 32'h00000055, "r0004");
    access(0, 4'h0, 32'h0007, 32'h0, 32'h00000055, "r0007");
    access(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, "r10 again");

    // Wait states on the wait-2 port
    access(1, 4'hF, 32'h20, 32'h0BADF00D, 32'h0, "w2 w20");
    access(1, 4'h0, 32'h20, 32'h0, 32'h0BADF00D, "w2 r20");

    // Abandoned write on the wait-3 port
    access(2, 4'hF, 32'h40, 32'hA5A5A5A5, 32'h0, "w40");
    en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h40; wdata[2] = 32'h12345678;
    repeat (2) begin
      #1 chk("abandon stallreq", 32'(stall[2]), 32'h1);
      @(posedge clk); @(negedge clk);
    end
    en[2] = 1'b0;
    #1 chk("abandon idle stallreq", 32'(stall[2]), 32'h0);
    @(posedge clk); @(negedge clk);
    access(2, 4'h0, 32'h40, 32'h0, 32'hA5A5A5A5, "r40");

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
